// File: rtl/vram_bus_bridge_if.sv
// CPU-side and VRAM-side signal bundle for vram_bus_bridge.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
`timescale 1ns/1ps

interface vram_bus_bridge_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] cpuAddr;
   logic [7:0]        cpuDataIn;
   logic              cpuRw;
   logic              cpuDs;
   logic [7:0]        cpuRdData;
   logic              cpuRdValid;
   logic              busy;
   logic [10:0]       vramAddr;
   logic [7:0]        vramDataIn;
   logic              vramStrobe;
   logic              vramWrite;
   logic [7:0]        vramDataOut;

   modport slave (
      input  cpuAddr, cpuDataIn, cpuRw, cpuDs, vramDataOut,
      output cpuRdData, cpuRdValid, busy, vramAddr, vramDataIn, vramStrobe, vramWrite
   );

   modport master (
      output cpuAddr, cpuDataIn, cpuRw, cpuDs, vramDataOut,
      input  cpuRdData, cpuRdValid, busy, vramAddr, vramDataIn, vramStrobe, vramWrite
   );
endinterface

// File: rtl/vram_bus_bridge.sv
// Z8 bus to 2 KiB frame-buffer bridge: one single-cycle VRAM strobe per CPU data-strobe cycle.
// Define VRAM_BRIDGE_SYNC_EN to pass cpuDs through a 2-flop synchronizer (+2 cycles latency).
`timescale 1ns/1ps

module vram_bus_bridge #(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h1000
) (
   input  logic                    clk,
   input  logic                    reset,
   vram_bus_bridge_if.slave        bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

   state_e      state_q, state_d;
   logic [10:0] vram_addr_q, vram_addr_d;
   logic [7:0]  vram_data_q, vram_data_d;
   logic        vram_write_q, vram_write_d;
   logic        vram_strobe_q, vram_strobe_d;
   logic        busy_q, busy_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        ds_prev_q;
   logic        armed_q, armed_d;
   logic        ds_act;
   logic        ds_valid;
   logic        start;
   logic        hit;

`ifdef VRAM_BRIDGE_SYNC_EN
   logic [1:0] ds_sync_q, ds_sync_d;
   logic [1:0] warm_q, warm_d;

   always_comb begin
      ds_sync_d = {ds_sync_q[0], ~bus.cpuDs};
      warm_d    = {warm_q[0], 1'b1};
      ds_act    = ds_sync_q[1];
      ds_valid  = warm_q[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ds_sync_q <= 2'b00;
         warm_q    <= 2'b00;
      end else begin
         ds_sync_q <= ds_sync_d;
         warm_q    <= warm_d;
      end
   end
`else
   always_comb begin
      ds_act   = ~bus.cpuDs;
      ds_valid = 1'b1;
   end
`endif

   // A strobe already held low when reset releases is not a fresh edge; wait for one idle cycle.
   assign armed_d = armed_q | (ds_valid & ~ds_act);
   assign start   = armed_q & ds_act & ~ds_prev_q;
   assign hit     = (bus.cpuAddr[ADDR_W-1:11] == BASE_ADDR[ADDR_W-1:11]);

   always_comb begin
      state_d       = state_q;
      vram_addr_d   = vram_addr_q;
      vram_data_d   = vram_data_q;
      vram_write_d  = vram_write_q;
      vram_strobe_d = vram_strobe_q;
      busy_d        = busy_q;
      rd_data_d     = rd_data_q;
      rd_valid_d    = rd_valid_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (hit) begin
                  vram_addr_d   = bus.cpuAddr[10:0];
                  vram_data_d   = bus.cpuDataIn;
                  vram_write_d  = ~bus.cpuRw;
                  vram_strobe_d = 1'b1;
                  busy_d        = 1'b1;
                  rd_valid_d    = 1'b0;
                  state_d       = StIssue;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StIssue: begin
            vram_strobe_d = 1'b0;
            vram_write_d  = 1'b0;
            if (vram_write_q) begin
               busy_d  = 1'b0;
               state_d = StDone;
            end else begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            rd_data_d  = bus.vramDataOut;
            rd_valid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = StDone;
         end
         StDone: begin
            if (!ds_act) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         vram_addr_q   <= '0;
         vram_data_q   <= '0;
         vram_write_q  <= 1'b0;
         vram_strobe_q <= 1'b0;
         busy_q        <= 1'b0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         ds_prev_q     <= 1'b0;
         armed_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         vram_addr_q   <= vram_addr_d;
         vram_data_q   <= vram_data_d;
         vram_write_q  <= vram_write_d;
         vram_strobe_q <= vram_strobe_d;
         busy_q        <= busy_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         ds_prev_q     <= ds_act;
         armed_q       <= armed_d;
      end
   end

   assign bus.vramAddr   = vram_addr_q;
   assign bus.vramDataIn = vram_data_q;
   assign bus.vramWrite  = vram_write_q;
   assign bus.vramStrobe = vram_strobe_q;
   assign bus.busy       = busy_q;
   assign bus.cpuRdData  = rd_data_q;
   assign bus.cpuRdValid = rd_valid_q;

endmodule
